// File: rtl/mem_stage_data_memory_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes,
// responder FSM states and the alignment rule used by the lane logic.
package mem_stage_pkg;

    // Size codes carried on MemReadIn / MemWriteIn
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    // Instruction bit that turns lb/lh into lbu/lhu
    localparam int UNSIGNED_LOAD_BIT = 28;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    // A word must sit on a 4-byte boundary and a half on a 2-byte boundary
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_WORD: return (offset != 2'b00);
            SZ_HALF: return offset[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_data_memory_if.sv
// EX/MEM access bus between the pipeline and the data memory responder.
interface mem_stage_data_memory_if;
    logic [31:0] InstructionIn;
    logic [31:0] ALUResultIn;
    logic [31:0] ReadData2In;
    logic [1:0]  MemWriteIn;
    logic [1:0]  MemReadIn;
    logic [31:0] ReadDataOut;
    logic        Stall;
    logic        AlignError;

    // Pipeline side: issues the access, receives data and the stall request
    modport master (
        output InstructionIn, ALUResultIn, ReadData2In, MemWriteIn, MemReadIn,
        input  ReadDataOut, Stall, AlignError
    );

    // Memory side
    modport slave (
        input  InstructionIn, ALUResultIn, ReadData2In, MemWriteIn, MemReadIn,
        output ReadDataOut, Stall, AlignError
    );
endinterface

// File: rtl/mem_stage_data_memory_lane_align.sv
// Byte-lane steering for the data memory: store lane replication with
// byte enables, load lane extraction with sign/zero extension, and the
// illegal-access detector.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  wr_size,
    input  logic [1:0]  rd_size,
    input  logic        unsigned_load,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_value,
    output logic        illegal
);

    logic [31:0] shifted_word;

    // Illegal if either side is misaligned or both a load and a store are asked for
    always_comb begin
        illegal = misaligned(wr_size, offset)
                | misaligned(rd_size, offset)
                | ((wr_size != SZ_NONE) && (rd_size != SZ_NONE));
    end

    // Byte enables pick the lanes the store touches; untouched lanes keep their data
    always_comb begin
        byte_en = 4'b0000;
        case (wr_size)
            SZ_WORD: byte_en = 4'b1111;
            SZ_HALF: byte_en = offset[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: byte_en = 4'b0001 << offset;
            default: byte_en = 4'b0000;
        endcase
    end

    // Replicate the right-justified store data onto every lane so the byte
    // enables alone select where it lands
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            assign store_lanes[8*gi +: 8] =
                (wr_size == SZ_WORD) ? store_data[8*gi +: 8] :
                (wr_size == SZ_HALF) ? store_data[8*(gi % 2) +: 8] :
                                       store_data[7:0];
        end
    endgenerate

    assign shifted_word = mem_word >> {offset, 3'b000};

    // Extract the addressed lanes and extend to 32 bits
    always_comb begin
        load_value = 32'h0;
        case (rd_size)
            SZ_WORD: load_value = mem_word;
            SZ_HALF: load_value = unsigned_load ? {16'h0, shifted_word[15:0]}
                                                : {{16{shifted_word[15]}}, shifted_word[15:0]};
            SZ_BYTE: load_value = unsigned_load ? {24'h0, shifted_word[7:0]}
                                                : {{24{shifted_word[7]}}, shifted_word[7:0]};
            default: load_value = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage_data_memory.sv
// MEM-stage data memory responder. Holds the pipeline with Stall for
// LATENCY cycles per access, performs the load/store on the last stall
// edge and presents the result during a one-cycle DONE state.
module mem_stage_data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    mem_stage_data_memory_if.slave bus
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_e      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [31:0] result_reg;
    logic        error_reg;

    logic        request;
    logic        do_access;
    logic        stall;
    logic        write_commit;
    logic [AW-1:0] word_index;
    logic [31:0] mem_word;
    logic [3:0]  byte_en;
    logic [3:0]  lane_we;
    logic [31:0] store_lanes;
    logic [31:0] load_value;
    logic        illegal;

    // Address bits above the array wrap around; only bit 28 of the instruction matters here
    logic        unused_bits;
    assign unused_bits = ^{bus.InstructionIn[31:UNSIGNED_LOAD_BIT+1],
                           bus.InstructionIn[UNSIGNED_LOAD_BIT-1:0],
                           bus.ALUResultIn[31:AW+2]};

    assign request    = (bus.MemReadIn != SZ_NONE) || (bus.MemWriteIn != SZ_NONE);
    assign word_index = bus.ALUResultIn[AW+1:2];

    mem_lane_align u_lane_align (
        .offset        (bus.ALUResultIn[1:0]),
        .wr_size       (bus.MemWriteIn),
        .rd_size       (bus.MemReadIn),
        .unsigned_load (bus.InstructionIn[UNSIGNED_LOAD_BIT]),
        .store_data    (bus.ReadData2In),
        .mem_word      (mem_word),
        .byte_en       (byte_en),
        .store_lanes   (store_lanes),
        .load_value    (load_value),
        .illegal       (illegal)
    );

    // State and down-counter; asynchronous reset drops any WAIT in progress,
    // which is what aborts an in-flight store before it reaches the array
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next state, stall and the single access strobe
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        stall      = 1'b0;
        do_access  = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = request;
                if (request) begin
                    count_next = COUNT_INIT;
                    if (LATENCY > 1) begin
                        state_next = WAIT;
                    end else begin
                        do_access  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            WAIT: begin
                stall      = 1'b1;
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    do_access  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Inputs may still show the old request; it is not taken again
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign write_commit = do_access && (bus.MemWriteIn != SZ_NONE) && !illegal;
    assign lane_we      = byte_en & {4{write_commit}};

    // One byte-wide array per lane so each lane has its own write enable
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Byte-lane write on the access edge
            always_ff @(posedge Clock) begin
                if (lane_we[gi]) begin
                    lane_mem[word_index] <= store_lanes[8*gi +: 8];
                end
            end

            assign mem_word[8*gi +: 8] = lane_mem[word_index];
        end
    endgenerate

    // Load result and error flag, updated only on the access edge
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            result_reg <= 32'h0;
            error_reg  <= 1'b0;
        end else if (do_access) begin
            if (illegal) begin
                result_reg <= 32'h0;
                error_reg  <= 1'b1;
            end else begin
                error_reg <= 1'b0;
                if (bus.MemReadIn != SZ_NONE) begin
                    result_reg <= load_value;
                end
            end
        end
    end

    assign bus.ReadDataOut = result_reg;
    assign bus.AlignError  = error_reg;
    assign bus.Stall       = stall;

endmodule

// File: tb/tb_mem_stage_data_memory.sv
// Bench for mem_stage_data_memory: three instances (LATENCY 2, 1, 4) driven
// one at a time. The driver predicts each response from a byte-array model
// and queues it; per-instance monitors pop and compare at each DONE cycle.
module tb_mem_stage_data_memory;

    localparam int NI    = 3;
    localparam int DEPTH = 1024;
    localparam int NB    = DEPTH * 4;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        t_rst   [NI];
    logic [31:0] t_inst  [NI];
    logic [31:0] t_addr  [NI];
    logic [31:0] t_wdata [NI];
    logic [1:0]  t_mw    [NI];
    logic [1:0]  t_mr    [NI];
    logic [31:0] t_rdata [NI];
    logic        t_stall [NI];
    logic        t_err   [NI];

    // Reference memory, byte addressed
    logic [7:0]  mdl [NI][NB];

    // {check_data, align_error, data}
    logic [33:0] exp_q [$];

    int n_cmp  = 0;
    int n_fail = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

            mem_stage_data_memory_if ifc ();

            assign ifc.InstructionIn = t_inst[gi];
            assign ifc.ALUResultIn   = t_addr[gi];
            assign ifc.ReadData2In   = t_wdata[gi];
            assign ifc.MemWriteIn    = t_mw[gi];
            assign ifc.MemReadIn     = t_mr[gi];
            assign t_rdata[gi]       = ifc.ReadDataOut;
            assign t_stall[gi]       = ifc.Stall;
            assign t_err[gi]         = ifc.AlignError;

            mem_stage_data_memory #(.DEPTH(DEPTH), .LATENCY(L)) u_dut (
                .Clock (Clock),
                .Reset (t_rst[gi]),
                .bus   (ifc)
            );

            // Monitor: a falling Stall marks the DONE cycle
            initial begin : mon
                int          run;
                logic        prev;
                logic [33:0] e;
                run  = 0;
                prev = 1'b0;
                forever begin
                    @(negedge Clock);
                    if (t_rst[gi]) begin
                        run  = 0;
                        prev = 1'b0;
                    end else begin
                        if (t_stall[gi]) begin
                            run++;
                        end else if (prev) begin
                            n_cmp++;
                            if (run != L) begin
                                n_fail++;
                                $display("FAIL stall_len inst%0d: got %0d cycles, want %0d", gi, run, L);
                            end
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_fail++;
                                $display("FAIL unexpected_done inst%0d: got a response, want none", gi);
                            end else begin
                                e = exp_q.pop_front();
                                n_cmp++;
                                if (t_err[gi] !== e[32]) begin
                                    n_fail++;
                                    $display("FAIL align_error inst%0d: got %b, want %b", gi, t_err[gi], e[32]);
                                end
                                if (e[33]) begin
                                    n_cmp++;
                                    if (t_rdata[gi] !== e[31:0]) begin
                                        n_fail++;
                                        $display("FAIL read_data inst%0d: got %h, want %h", gi, t_rdata[gi], e[31:0]);
                                    end
                                end
                                $display("inst%0d done: data=%h err=%b stall=%0d", gi, t_rdata[gi], t_err[gi], run);
                            end
                            run = 0;
                        end
                        prev = t_stall[gi];
                    end
                end
            end
        end
    endgenerate

    // Issue one access, predict the response, then hold until DONE has passed
    task automatic access(input int k, input logic [1:0] rd, input logic [1:0] wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic uns);
        int          a;
        int          nbytes;
        int          size;
        logic        bad;
        logic [31:0] v;
        logic        prev;
        logic        seen;
        a      = int'(addr) & (NB - 1);
        size   = (rd != 2'd0) ? int'(rd) : int'(wr);
        nbytes = (size == 1) ? 4 : ((size == 2) ? 2 : 1);
        bad    = (rd != 2'd0 && wr != 2'd0)
               || (size == 1 && (a % 4) != 0)
               || (size == 2 && (a % 2) != 0);
        if (bad) begin
            exp_q.push_back({1'b1, 1'b1, 32'h0});
        end else if (rd != 2'd0) begin
            v = 32'h0;
            for (int i = 0; i < nbytes; i++) v = v | (32'(mdl[k][a + i]) << (8 * i));
            if (!uns && nbytes == 2) v = {{16{v[15]}}, v[15:0]};
            if (!uns && nbytes == 1) v = {{24{v[7]}}, v[7:0]};
            exp_q.push_back({1'b1, 1'b0, v});
        end else begin
            for (int i = 0; i < nbytes; i++) mdl[k][a + i] = 8'(wdata >> (8 * i));
            exp_q.push_back({1'b0, 1'b0, 32'h0});
        end
        v = $urandom & 32'hEFFF_FFFF;
        t_inst[k]  = uns ? (v | 32'h1000_0000) : v;
        t_addr[k]  = addr;
        t_wdata[k] = wdata;
        t_mr[k]    = rd;
        t_mw[k]    = wr;
        prev = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge Clock);
            if (prev && !t_stall[k]) seen = 1'b1;
            prev = t_stall[k];
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout inst%0d: got no DONE in 40 cycles, want one", k);
        end
        @(posedge Clock);
        #1;
        t_mr[k] = 2'd0;
        t_mw[k] = 2'd0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] r;
        int          op;
        logic [1:0]  sz;
        for (int k = 0; k < NI; k++) begin
            t_rst[k] = 1'b1; t_inst[k] = 32'h0; t_addr[k] = 32'h0;
            t_wdata[k] = 32'h0; t_mw[k] = 2'd0; t_mr[k] = 2'd0;
        end
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_data inst%0d", k), t_rdata[k], 32'h0);
            check($sformatf("reset_err inst%0d", k), 32'(t_err[k]), 32'h0);
            check($sformatf("reset_stall inst%0d", k), 32'(t_stall[k]), 32'h0);
        end
        @(posedge Clock);
        #1;
        for (int k = 0; k < NI; k++) t_rst[k] = 1'b0;

        // Fill the region used below with zeros
        for (int k = 0; k < NI; k++)
            for (int w = 0; w < 64; w++) access(k, 2'd0, 2'd1, 32'(w * 4), 32'h0, 1'b0);

        // Word, half, byte and misaligned sequence on the LATENCY=2 instance
        access(0, 2'd0, 2'd1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(0, 2'd1, 2'd0, 32'h10, 32'h0, 1'b0);
        access(0, 2'd0, 2'd1, 32'h10, 32'h80FF7F01, 1'b0);
        access(0, 2'd3, 2'd0, 32'h13, 32'h0, 1'b0);
        access(0, 2'd3, 2'd0, 32'h13, 32'h0, 1'b1);
        access(0, 2'd2, 2'd0, 32'h10, 32'h0, 1'b0);
        access(0, 2'd2, 2'd0, 32'h12, 32'h0, 1'b1);
        access(0, 2'd0, 2'd3, 32'h11, 32'hFFFF_FFAB, 1'b0);
        access(0, 2'd1, 2'd0, 32'h10, 32'h0, 1'b0);
        access(0, 2'd0, 2'd2, 32'h12, 32'hCDEF_1234, 1'b0);
        access(0, 2'd1, 2'd0, 32'h10, 32'h0, 1'b0);
        access(0, 2'd1, 2'd0, 32'h12, 32'h0, 1'b0);
        access(0, 2'd0, 2'd2, 32'h11, 32'h0000_5555, 1'b0);
        access(0, 2'd1, 2'd0, 32'h10, 32'h0, 1'b0);

        // Back-to-back loads on the LATENCY=1 instance
        access(1, 2'd0, 2'd1, 32'h40, 32'h11223344, 1'b0);
        access(1, 2'd1, 2'd0, 32'h40, 32'h0, 1'b0);
        access(1, 2'd3, 2'd0, 32'h41, 32'h0, 1'b0);

        // Reset during the second stall cycle of a store on the LATENCY=4 instance
        access(2, 2'd0, 2'd1, 32'h24, 32'hCAFEF00D, 1'b0);
        access(2, 2'd1, 2'd0, 32'h24, 32'h0, 1'b0);
        t_inst[2] = 32'h0; t_addr[2] = 32'h20; t_wdata[2] = 32'h55; t_mw[2] = 2'd1;
        @(posedge Clock);
        #1;
        t_rst[2] = 1'b1;
        t_mw[2]  = 2'd0;
        #1;
        check("abort_data", t_rdata[2], 32'h0);
        check("abort_err", 32'(t_err[2]), 32'h0);
        check("abort_stall", 32'(t_stall[2]), 32'h0);
        @(posedge Clock);
        #1;
        t_rst[2] = 1'b0;
        access(2, 2'd1, 2'd0, 32'h20, 32'h0, 1'b0);

        // Random mix with upper address bits that must wrap away
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 60; n++) begin
                op = $urandom_range(0, 9);
                sz = 2'($urandom_range(1, 3));
                r  = $urandom;
                r  = (r & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
                if (op == 0)      access(k, sz, 2'($urandom_range(1, 3)), r, $urandom, 1'($urandom_range(0, 1)));
                else if (op < 5)  access(k, sz, 2'd0, r, $urandom, 1'($urandom_range(0, 1)));
                else              access(k, 2'd0, sz, r, $urandom, 1'b0);
            end
        end

        repeat (5) @(posedge Clock);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
